cshm_shift_accumulate: RTL
==========================

// Module: cshm_shift_accumulate
// PURPOSE
//   Sequential CSHM MAC engine downstream of the 8:1 alphabet multiplexer in the FIR datapath.
//   - Per output sample, walks NTAPS taps, two coefficient nibbles per tap.
//   - For each nibble, drives the tap index and the mux select, then shifts and accumulates mux_out.
//   - Emits one filtered sample per accepted input.
// PARAMETERS
//   NTAPS      8   taps per output; tap index width TAP_W = $clog2(NTAPS)
//   DATA_W     16  width of mux_out and y
//   COEF_W     9   sign-magnitude coefficient: [8] sign, [7:0] magnitude (two nibbles)
//   ACC_W      32  accumulator width, two's complement
//   OUT_SHIFT  8   arithmetic right shift from accumulator to y
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       new sample available; start a run
//   in_ready   out  1       high only in IDLE
//   tap_sel    out  TAP_W   tap index to sample delay line / precomputer
//   coef_addr  out  TAP_W   coefficient ROM address (= tap_sel)
//   coef_data  in   COEF_W  coefficient, combinational ROM, valid same cycle
//   select     out  3       alphabet select to mux (0..7 -> x1..x15)
//   mux_out    in   DATA_W  signed selected odd multiple, valid same cycle as select/tap_sel
//   y          out  DATA_W  filtered output, held until next y_valid
//   y_valid    out  1       one-cycle pulse when y updates
// BEHAVIOUR
//   Reset: state=IDLE, acc=0, tap=0, nib=0, y=0, y_valid=0, in_ready=1, select=0, tap_sel=0.
//   FSM: IDLE -(in_valid)-> RUN -(tap==NTAPS-1 && nib==1)-> DONE -> IDLE.
//   IDLE: acceptance edge clears acc, sets tap=0, nib=0; in_valid ignored in RUN/DONE.
//   RUN: 1 cycle per nibble, nib 0 = coef_data[3:0], nib 1 = coef_data[7:4], then tap++.
//   Decoding of nibble n (4-bit):
//     - n=0: term=0, select=0.
//     - else s = trailing zeros of n (0..3); select = ((n>>s)-1)>>1.
//   Term: sext(mux_out, ACC_W) << (s + 4*nib); acc -= term if coef_data[8] else acc += term.
//     - Magnitude 0 with sign 1 contributes 0.
//   Overflow: acc wraps modulo 2^ACC_W; no overflow flag.
//   DONE: y <= f(acc >>> OUT_SHIFT); y_valid=1 for this cycle only; next cycle IDLE.
//   Latency: y_valid high exactly 2*NTAPS+1 cycles after the acceptance edge.
//   Throughput: one sample per 2*NTAPS+2 cycles.
//   Outputs tap_sel/coef_addr/select are combinational from tap, nib, coef_data; 0 outside RUN.
//   Reset asserted mid-run: immediate return to reset values; the partial result is discarded, no y_valid.
// CONFIGURATION
//   CSHM_SAT_EN defined:
//     - f saturates the shifted acc to the signed DATA_W range: [-32768, 32767] at default.
//   CSHM_SAT_EN undefined:
//     - f truncates to the low DATA_W bits, which wraps on overflow.
// STRUCTURE
//   Package cshm_pkg:
//     - state enum {IDLE,RUN,DONE}.
//     - nibble decode function returning {select[2:0], shift[1:0], zero}.
//     - NIB_W=4 constant.
//   Sub-module cshm_nibble_decode: purely combinational, 4-bit in -> select/shift/zero.
//     - Instanced once; FSM, accumulator and output stage stay in the top.
// TESTING
//   Bench models mux_out = sample[tap_sel]*(2*select+1); all scenarios use OUT_SHIFT=0 unless stated.
//   1 All coef=+1, all samples=3 -> y=24 at cycle 17 after accept; y_valid exactly 1 cycle.
//   2 coef[0]=0x03C (+60), others 0, sample[0]=2:
//       - nib0 select=1, shift 2; nib1 select=1, shift 4.
//       - y=120.
//   3 coef[0]=0x1FF (-255), sample[0]=100, others 0 -> y=-25500 (wrapped to 16 bits when CSHM_SAT_EN undefined).
//   4 Same as 3 with CSHM_SAT_EN defined and sample=200 -> y=-32768; default OUT_SHIFT=8, coef +1 x8, sample 256 -> y=8.
//   5 in_valid held high through run -> in_ready low, no restart; second run accepted only from IDLE, y_valid spacing 18 cycles.
//   6 rst_n low at run cycle 7 -> all outputs at reset values, no y_valid; new run after release gives correct y.

Source files
------------

// File: rtl/cshm_pkg.sv
// Shared types and the nibble decode rule for the CSHM shift-accumulate engine.
package cshm_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [2:0] select;
    logic [1:0] shift;
    logic       zero;
  } nib_dec_t;

  // A nibble n is rewritten as odd << s, odd in {1,3,..,15}; select indexes the odd multiple.
  function automatic nib_dec_t nib_decode(input logic [NIB_W-1:0] n);
    nib_dec_t d;
    logic [NIB_W-1:0] odd;
    d = '0;
    if (n[0])      d.shift = 2'd0;
    else if (n[1]) d.shift = 2'd1;
    else if (n[2]) d.shift = 2'd2;
    else           d.shift = 2'd3;
    odd      = n >> d.shift;
    d.select = odd[3:1];
    d.zero   = (n == '0);
    return d;
  endfunction

endpackage

// File: rtl/cshm_nibble_decode.sv
// Combinational nibble decoder: 4-bit coefficient nibble -> alphabet select, shift, zero flag.
module cshm_nibble_decode
  import cshm_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [2:0]       select,
  output logic [1:0]       shift,
  output logic             zero
);

  nib_dec_t d;

  assign d      = nib_decode(nib);
  assign select = d.select;
  assign shift  = d.shift;
  assign zero   = d.zero;

endmodule

// File: rtl/cshm_shift_accumulate.sv
// Sequential CSHM MAC: walks NTAPS taps, two coefficient nibbles each, accumulating shifted mux_out.
// Define CSHM_SAT_EN to saturate y to the signed DATA_W range instead of truncating.
module cshm_shift_accumulate
  import cshm_pkg::*;
#(
  parameter  int NTAPS     = 8,
  parameter  int DATA_W    = 16,
  parameter  int COEF_W    = 9,
  parameter  int ACC_W     = 32,
  parameter  int OUT_SHIFT = 8,
  localparam int TAP_W     = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [TAP_W-1:0]         tap_sel,
  output logic [TAP_W-1:0]         coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [2:0]               select,
  input  logic signed [DATA_W-1:0] mux_out,
  output logic [DATA_W-1:0]        y,
  output logic                     y_valid
);

  state_t                    state, state_nxt;
  logic [TAP_W-1:0]          tap;
  logic                      nib;
  logic signed [ACC_W-1:0]   acc, term, mux_ext;
  logic [NIB_W-1:0]          nibble;
  logic [2:0]                dec_select;
  logic [1:0]                dec_shift;
  logic                      dec_zero;
  logic                      last;
  logic                      running;
  logic [DATA_W-1:0]         y_next;

  assign running = (state == RUN);
  assign last    = nib && (tap == TAP_W'(NTAPS - 1));
  assign nibble  = nib ? coef_data[2*NIB_W-1:NIB_W] : coef_data[NIB_W-1:0];

  cshm_nibble_decode u_dec (
    .nib    (nibble),
    .select (dec_select),
    .shift  (dec_shift),
    .zero   (dec_zero)
  );

  assign in_ready  = (state == IDLE);
  assign tap_sel   = running ? tap : '0;
  assign coef_addr = tap_sel;
  assign select    = running ? dec_select : '0;

  // Total weight of the nibble term is 2^(s + 4*nib), i.e. shift amount {nib, s}.
  assign mux_ext = {{(ACC_W-DATA_W){mux_out[DATA_W-1]}}, mux_out};
  assign term    = dec_zero ? '0 : (mux_ext <<< {nib, dec_shift});

`ifdef CSHM_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
  logic signed [ACC_W-1:0] shifted;
  assign shifted = acc >>> OUT_SHIFT;
  always_comb begin
    y_next = shifted[DATA_W-1:0];
    if (shifted > Y_MAX)      y_next = Y_MAX[DATA_W-1:0];
    else if (shifted < Y_MIN) y_next = Y_MIN[DATA_W-1:0];
  end
`else
  assign y_next = DATA_W'(acc >>> OUT_SHIFT);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      tap     <= '0;
      nib     <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      y_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          acc <= '0;
          tap <= '0;
          nib <= 1'b0;
        end
        RUN: begin
          acc <= coef_data[COEF_W-1] ? (acc - term) : (acc + term);
          nib <= ~nib;
          if (nib) tap <= last ? '0 : tap + TAP_W'(1);
        end
        DONE: begin
          y       <= y_next;
          y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
